// File: rtl/turn_queue.sv
// turn_queue: filters direction commands into a bounded turn FIFO, popped one per game tick; owns pause.
module turn_queue #(
  parameter int         DEPTH     = 2,
  parameter logic [1:0] START_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] epp_data,
  input  logic       epp_wr,
  input  logic       step,
  input  logic       new_game,
  output logic [1:0] dir,
  output logic       paused,
  output logic [2:0] pending,
  output logic [7:0] drop_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [1:0]    q_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
  logic [1:0]    dir_q, dir_d, ref_dir, turn;
  logic [2:0]    cnt_q, cnt_d, cnt_pp;
  logic [7:0]    drop_q, drop_d;
  logic          paused_q, paused_d, wr, pop, is_turn, reject, full, push, drop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    wr       = epp_wr & ~new_game;
    pop      = step & ~new_game & ~paused_q & (cnt_q != 3'd0);
    dir_d    = new_game ? START_DIR : pop ? q_q[head_q] : dir_q;
    cnt_pp   = cnt_q - {2'b0, pop};
    tail_m1  = (tail_q == '0) ? PW'(DEPTH - 1) : tail_q - PW'(1);
    // Filter against the newest queued turn, or the heading being committed now if the queue drains.
    ref_dir  = (cnt_pp != 3'd0) ? q_q[tail_m1] : dir_d;
    turn     = epp_data[1:0];
    is_turn  = wr & (epp_data[3:2] == 2'b00);
    reject   = is_turn & ((turn == ref_dir) | (turn == (ref_dir ^ 2'd2)));
    full     = cnt_pp == 3'(DEPTH);
    push     = is_turn & ~reject & ~full;
    drop     = is_turn & ~push;
    cnt_d    = new_game ? 3'd0 : cnt_pp + {2'b0, push};
    head_d   = new_game ? '0 : pop ? inc(head_q) : head_q;
    tail_d   = new_game ? '0 : push ? inc(tail_q) : tail_q;
    paused_d = ~new_game & (paused_q ^ (wr & (epp_data == 4'd4)));
    drop_d   = drop_q + {7'b0, drop & (drop_q != 8'hff)};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q    <= START_DIR;
      paused_q <= 1'b0;
      cnt_q    <= 3'd0;
      drop_q   <= 8'd0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      dir_q    <= dir_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) q_q[tail_q] <= turn;
  end
  assign dir      = dir_q;
  assign paused   = paused_q;
  assign pending  = cnt_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_turn_queue.sv
// tb_turn_queue: table vectors plus randomized run against a list-based model, DEPTH=2 and DEPTH=3.
module tb_turn_queue;
  logic       clk = 1'b0, rst = 1'b0, epp_wr = 1'b0, step = 1'b0, new_game = 1'b0;
  logic [3:0] epp_data = 4'd0;
  logic [1:0] dir2, dir3;
  logic       paused2, paused3;
  logic [2:0] pend2, pend3;
  logic [7:0] drop2, drop3;
  int n_chk = 0, n_fail = 0;
  int m_dir [2], m_p [2], m_n [2], m_drop [2];
  int m_q [2][5];
  typedef struct {int wr, data, st, ng, dir, p, pend, drop;} vec_t;
  vec_t tv [$];

  always #5 clk = ~clk;

  turn_queue #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .epp_data(epp_data), .epp_wr(epp_wr), .step(step),
    .new_game(new_game), .dir(dir2), .paused(paused2), .pending(pend2), .drop_cnt(drop2));
  turn_queue #(.DEPTH(3)) u3 (.clk(clk), .rst(rst), .epp_data(epp_data), .epp_wr(epp_wr), .step(step),
    .new_game(new_game), .dir(dir3), .paused(paused3), .pending(pend3), .drop_cnt(drop3));

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dir[k] = 1; m_p[k] = 0; m_n[k] = 0; m_drop[k] = 0;
    end
  endtask

  task automatic model_cyc(input int k, input int dp, input int wr, input int data, input int st, input int ng);
    int r;
    if (ng != 0) begin
      m_dir[k] = 1; m_n[k] = 0; m_p[k] = 0;
    end else begin
      if (st != 0 && m_p[k] == 0 && m_n[k] > 0) begin
        m_dir[k] = m_q[k][0];
        for (int i = 0; i < 4; i++) m_q[k][i] = m_q[k][i+1];
        m_n[k]--;
      end
      if (wr != 0 && data == 4) m_p[k] = 1 - m_p[k];
      else if (wr != 0 && data < 4) begin
        r = (m_n[k] > 0) ? m_q[k][m_n[k]-1] : m_dir[k];
        if (data == r || data == (r ^ 2) || m_n[k] == dp) m_drop[k] = (m_drop[k] < 255) ? m_drop[k] + 1 : 255;
        else begin
          m_q[k][m_n[k]] = data;
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic check_inst(input int k);
    chk($sformatf("dir_d%0d", k + 2), (k == 0) ? int'(dir2) : int'(dir3), m_dir[k]);
    chk($sformatf("paused_d%0d", k + 2), (k == 0) ? int'(paused2) : int'(paused3), m_p[k]);
    chk($sformatf("pending_d%0d", k + 2), (k == 0) ? int'(pend2) : int'(pend3), m_n[k]);
    chk($sformatf("drop_d%0d", k + 2), (k == 0) ? int'(drop2) : int'(drop3), m_drop[k]);
  endtask

  task automatic cyc(input int wr, input int data, input int st, input int ng);
    epp_wr = wr[0]; epp_data = 4'(data); step = st[0]; new_game = ng[0];
    @(posedge clk);
    model_cyc(0, 2, wr, data, st, ng);
    model_cyc(1, 3, wr, data, st, ng);
    #1;
    epp_wr = 1'b0; step = 1'b0; new_game = 1'b0; epp_data = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tv.push_back('{0,0,1,0, 1,0,0,0});
    tv.push_back('{0,0,1,0, 1,0,0,0});
    tv.push_back('{0,0,1,0, 1,0,0,0});
    tv.push_back('{1,0,0,0, 1,0,1,0});
    tv.push_back('{1,3,0,0, 1,0,2,0});
    tv.push_back('{0,0,1,0, 0,0,1,0});
    tv.push_back('{0,0,1,0, 3,0,0,0});
    tv.push_back('{0,0,0,1, 1,0,0,0});
    tv.push_back('{1,3,0,0, 1,0,0,1});
    tv.push_back('{1,1,0,0, 1,0,0,2});
    tv.push_back('{1,9,0,0, 1,0,0,2});
    tv.push_back('{1,0,0,0, 1,0,1,2});
    tv.push_back('{1,3,0,0, 1,0,2,2});
    tv.push_back('{1,2,0,0, 1,0,2,3});
    tv.push_back('{1,2,1,0, 0,0,2,3});
    tv.push_back('{0,0,1,0, 3,0,1,3});
    tv.push_back('{0,0,1,0, 2,0,0,3});
    tv.push_back('{1,4,0,0, 2,1,0,3});
    tv.push_back('{1,1,0,0, 2,1,1,3});
    tv.push_back('{0,0,1,0, 2,1,1,3});
    tv.push_back('{1,4,1,0, 2,0,1,3});
    tv.push_back('{0,0,1,0, 1,0,0,3});
    tv.push_back('{1,1,0,0, 1,0,0,4});
    tv.push_back('{1,3,0,0, 1,0,0,5});
    tv.push_back('{1,0,0,0, 1,0,1,5});
    tv.push_back('{1,3,0,0, 1,0,2,5});
    tv.push_back('{1,4,0,0, 1,1,2,5});
    tv.push_back('{1,4,1,1, 1,0,0,5});
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
    rst = 1'b1;
    foreach (tv[i]) begin
      cyc(tv[i].wr, tv[i].data, tv[i].st, tv[i].ng);
      chk($sformatf("tbl%0d_dir", i), int'(dir2), tv[i].dir);
      chk($sformatf("tbl%0d_paused", i), int'(paused2), tv[i].p);
      chk($sformatf("tbl%0d_pending", i), int'(pend2), tv[i].pend);
      chk($sformatf("tbl%0d_drop", i), int'(drop2), tv[i].drop);
      check_inst(1);
    end
    cyc(1, 4, 0, 0);
    cyc(1, 0, 0, 0);
    check_inst(0);
    #1 rst = 1'b0;
    #1;
    chk("async_dir", int'(dir2), 1);
    chk("async_paused", int'(paused2), 0);
    chk("async_pending", int'(pend2), 0);
    chk("async_drop", int'(drop2), 0);
    model_reset();
    check_inst(1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 0);
      check_inst(0);
      check_inst(1);
    end
    chk("sat_drop", int'(drop2), 255);
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 500; i++) begin
        cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 63) == 0));
        check_inst(0);
        check_inst(1);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
